// File: rtl/alu_181.sv
// 8-bit 74181-style ALU: combinational result on a tri-stated bus plus a
// clocked status stage (result, carry, zero) for microcode branching.

module alu_181_bit (
    input  logic       a,
    input  logic       b,
    input  logic [3:0] s,
    output logic       x,
    output logic       y,
    output logic       lf
);
    // The 74181 generate/propagate terms; logic mode is their XNOR,
    // which reproduces all sixteen bitwise functions without a mux.
    assign x  = a | (b & s[0]) | (~b & s[1]);
    assign y  = (a & ~b & s[2]) | (a & b & s[3]);
    assign lf = ~(x ^ y);
endmodule

module alu_181 (
    input  logic       clk,
    input  logic       rst,
    input  logic       ALU_B,
    input  logic       S0,
    input  logic       S1,
    input  logic       S2,
    input  logic       S3,
    input  logic       M,
    input  logic       Cn,
    input  logic [7:0] DR1,
    input  logic [7:0] DR2,
    output logic [7:0] AUJ3,
    output logic       CN8,
    output logic [7:0] ALU_Q,
    output logic       CO_Q,
    output logic       ZF_Q
);
    localparam int VEC_W = 8;

    logic [3:0]       sel;
    logic [VEC_W-1:0] x_vec;
    logic [VEC_W-1:0] y_vec;
    logic [VEC_W-1:0] lf_vec;
    logic [VEC_W:0]   sum;
    logic [VEC_W-1:0] f;
    logic             cout;

    assign sel = {S3, S2, S1, S0};

    genvar i;
    generate
        for (i = 0; i < VEC_W; i++) begin : g_bit
            alu_181_bit u_bit (
                .a  (DR1[i]),
                .b  (DR2[i]),
                .s  (sel),
                .x  (x_vec[i]),
                .y  (y_vec[i]),
                .lf (lf_vec[i])
            );
        end
    endgenerate

    // Cn is active-low: a low carry-in adds one.
    assign sum  = {1'b0, x_vec} + {1'b0, y_vec} + {{VEC_W{1'b0}}, ~Cn};
    assign f    = M ? lf_vec : sum[VEC_W-1:0];
    assign cout = M ? 1'b0 : sum[VEC_W];

    assign AUJ3 = ALU_B ? {VEC_W{1'bz}} : f;
    assign CN8  = cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_Q <= '0;
            CO_Q  <= 1'b0;
            ZF_Q  <= 1'b0;
        end else begin
            ALU_Q <= f;
            CO_Q  <= cout;
            ZF_Q  <= (f == '0);
        end
    end
endmodule

// File: tb/tb_alu_181.sv
// Self-checking bench for alu_181: function-table reference model, random
// stimulus with a per-cycle compare, and directed literal checks.

module tb_alu_181;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ALU_B = 1'b0;
    logic       S0 = 1'b0, S1 = 1'b0, S2 = 1'b0, S3 = 1'b0;
    logic       M = 1'b0;
    logic       Cn = 1'b1;
    logic [7:0] DR1 = 8'h00, DR2 = 8'h00;
    logic [7:0] tb_val = 8'h00;
    wire  [7:0] bus;
    logic       CN8;
    logic [7:0] ALU_Q;
    logic       CO_Q, ZF_Q;

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    // When the DUT releases the bus the bench drives it, so a released bus
    // reads back exactly the bench pattern.
    assign bus = ALU_B ? tb_val : 8'hzz;

    alu_181 dut (
        .clk(clk), .rst(rst), .ALU_B(ALU_B),
        .S0(S0), .S1(S1), .S2(S2), .S3(S3), .M(M), .Cn(Cn),
        .DR1(DR1), .DR2(DR2),
        .AUJ3(bus), .CN8(CN8), .ALU_Q(ALU_Q), .CO_Q(CO_Q), .ZF_Q(ZF_Q)
    );

    always #5 clk = ~clk;

    // Returns {carry, F} from the published function tables.
    function automatic logic [8:0] ref_alu(input logic [3:0] s, input logic m,
                                           input logic cn, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [8:0] p, q;
        if (m) begin
            case (s)
                4'h0: return {1'b0, ~a};
                4'h1: return {1'b0, ~(a | b)};
                4'h2: return {1'b0, ~a & b};
                4'h3: return 9'h000;
                4'h4: return {1'b0, ~(a & b)};
                4'h5: return {1'b0, ~b};
                4'h6: return {1'b0, a ^ b};
                4'h7: return {1'b0, a & ~b};
                4'h8: return {1'b0, ~a | b};
                4'h9: return {1'b0, ~(a ^ b)};
                4'hA: return {1'b0, b};
                4'hB: return {1'b0, a & b};
                4'hC: return 9'h0FF;
                4'hD: return {1'b0, a | ~b};
                4'hE: return {1'b0, a | b};
                default: return {1'b0, a};
            endcase
        end
        // "minus 1" is adding 8'hFF; "A-B-1" is adding ~B.
        case (s)
            4'h0: begin p = {1'b0, a};      q = 9'h000; end
            4'h1: begin p = {1'b0, a | b};  q = 9'h000; end
            4'h2: begin p = {1'b0, a | ~b}; q = 9'h000; end
            4'h3: begin p = 9'h0FF;         q = 9'h000; end
            4'h4: begin p = {1'b0, a};      q = {1'b0, a & ~b}; end
            4'h5: begin p = {1'b0, a | b};  q = {1'b0, a & ~b}; end
            4'h6: begin p = {1'b0, a};      q = {1'b0, ~b}; end
            4'h7: begin p = {1'b0, a & ~b}; q = 9'h0FF; end
            4'h8: begin p = {1'b0, a};      q = {1'b0, a & b}; end
            4'h9: begin p = {1'b0, a};      q = {1'b0, b}; end
            4'hA: begin p = {1'b0, a | ~b}; q = {1'b0, a & b}; end
            4'hB: begin p = {1'b0, a & b};  q = 9'h0FF; end
            4'hC: begin p = {1'b0, a};      q = {1'b0, a}; end
            4'hD: begin p = {1'b0, a | b};  q = {1'b0, a}; end
            4'hE: begin p = {1'b0, a | ~b}; q = {1'b0, a}; end
            default: begin p = {1'b0, a};   q = 9'h0FF; end
        endcase
        return p + q + {8'h00, ~cn};
    endfunction

    function automatic logic [8:0] cur_ref();
        return ref_alu({S3, S2, S1, S0}, M, Cn, DR1, DR2);
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected register contents, built from the inputs present at each edge.
    logic [7:0] exp_q  = 8'h00;
    logic       exp_co = 1'b0;
    logic       exp_zf = 1'b0;
    always @(posedge clk) begin
        logic [8:0] r;
        r = cur_ref();
        if (rst) begin
            exp_q <= 8'h00; exp_co <= 1'b0; exp_zf <= 1'b0;
        end else begin
            exp_q <= r[7:0]; exp_co <= r[8]; exp_zf <= (r[7:0] == 8'h00);
        end
    end

    always @(negedge clk) begin
        logic [8:0] r;
        if (chk_en) begin
            r = cur_ref();
            check("bus", {1'b0, bus}, ALU_B ? {1'b0, tb_val} : {1'b0, r[7:0]});
            check("cn8", {8'h00, CN8}, {8'h00, r[8]});
            check("alu_q", {1'b0, ALU_Q}, {1'b0, exp_q});
            check("co_q", {8'h00, CO_Q}, {8'h00, exp_co});
            check("zf_q", {8'h00, ZF_Q}, {8'h00, exp_zf});
        end
    end

    task automatic set_fn(input logic [3:0] s, input logic m, input logic cn);
        {S3, S2, S1, S0} = s; M = m; Cn = cn;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [8:0] r;
        DR1 = 8'h65; DR2 = 8'hA7;
        set_fn(4'h9, 1'b0, 1'b0);
        tick(); tick();
        check("rst_alu_q", {1'b0, ALU_Q}, 9'h000);
        check("rst_co_q", {8'h00, CO_Q}, 9'h000);
        check("rst_zf_q", {8'h00, ZF_Q}, 9'h000);
        check("rst_bus", {1'b0, bus}, 9'h00D);
        tick();
        check("rst2_alu_q", {1'b0, ALU_Q}, 9'h000);
        rst = 1'b0;
        tick();
        check("rel_alu_q", {1'b0, ALU_Q}, 9'h00D);
        check("rel_co_q", {8'h00, CO_Q}, 9'h001);

        // Arithmetic S=9 and S=6
        set_fn(4'h9, 1'b0, 1'b1); #1;
        check("add_bus", {1'b0, bus}, 9'h00C);
        check("add_cn8", {8'h00, CN8}, 9'h001);
        set_fn(4'h9, 1'b0, 1'b0); #1;
        check("addc_bus", {1'b0, bus}, 9'h00D);
        tick();
        check("addc_alu_q", {1'b0, ALU_Q}, 9'h00D);
        check("addc_co_q", {8'h00, CO_Q}, 9'h001);
        check("addc_zf_q", {8'h00, ZF_Q}, 9'h000);
        set_fn(4'h6, 1'b0, 1'b0); #1;
        check("sub_bus", {1'b0, bus}, 9'h0BE);
        check("sub_cn8", {8'h00, CN8}, 9'h000);
        set_fn(4'h6, 1'b0, 1'b1); #1;
        check("subm1_bus", {1'b0, bus}, 9'h0BD);

        // Logic mode
        set_fn(4'h6, 1'b1, 1'b0); #1; check("xor_bus", {CN8, bus}, 9'h0C2);
        set_fn(4'hB, 1'b1, 1'b0); #1; check("and_bus", {CN8, bus}, 9'h025);
        set_fn(4'hE, 1'b1, 1'b0); #1; check("or_bus",  {CN8, bus}, 9'h0E7);
        set_fn(4'h0, 1'b1, 1'b0); #1; check("nota_bus", {CN8, bus}, 9'h09A);
        set_fn(4'h3, 1'b1, 1'b0); #1; check("zero_bus", {CN8, bus}, 9'h000);
        tick();
        check("zero_zf_q", {8'h00, ZF_Q}, 9'h001);

        // Released bus: bench pattern reads back, registers still load
        set_fn(4'h9, 1'b0, 1'b0);
        tb_val = 8'h00; ALU_B = 1'b1; #1;
        check("hiz_bus00", {1'b0, bus}, 9'h000);
        tb_val = 8'hFF; #1;
        check("hiz_busff", {1'b0, bus}, 9'h0FF);
        check("hiz_cn8", {8'h00, CN8}, 9'h001);
        tick();
        check("hiz_alu_q", {1'b0, ALU_Q}, 9'h00D);
        ALU_B = 1'b0; #1;
        check("drv_bus", {1'b0, bus}, 9'h00D);

        // Full function-table sweep against the model
        for (int k = 0; k < 64; k++) begin
            set_fn(k[3:0], k[5], k[4]); #1;
            r = cur_ref();
            check("sweep", {CN8, bus}, r);
            #99;
        end

        // Random phase with the per-cycle compare running
        @(posedge clk); #2;
        chk_en = 1'b1;
        for (int n = 0; n < 600; n++) begin
            DR1 = 8'($urandom); DR2 = 8'($urandom);
            set_fn(4'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) DR2 = DR1;
            ALU_B = ($urandom_range(0, 5) == 0);
            tb_val = 8'($urandom);
            rst = ($urandom_range(0, 31) == 0);
            @(posedge clk); #2;
        end
        chk_en = 1'b0;
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_181.md
# alu_181

8-bit 74181-style arithmetic/logic unit for the microprogrammed datapath. Operands come from data registers DR1 (A) and DR2 (B); the function is chosen by S3..S0, M and Cn. The combinational result drives the internal bus through an active-low output enable. A clocked status stage captures the result, carry and zero flag for microcode branching.

## Interface
- No parameters; the data width is fixed at 8 bits.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- ALU_B  input  1  active-low bus enable: 0 drives AUJ3, 1 tri-states AUJ3.
- S0, S1, S2, S3  input  1 each  function select; S3 is the MSB of code S = {S3,S2,S1,S0}.
- M  input  1  mode: 1 = logic, 0 = arithmetic.
- Cn  input  1  active-low carry-in: 0 adds 1, 1 adds nothing. Ignored when M=1.
- DR1  input  8  operand A.
- DR2  input  8  operand B.
- AUJ3  output  8  combinational result F on the bus; 8'hZZ when ALU_B=1.
- CN8  output  1  combinational active-high carry-out; 0 when M=1.
- ALU_Q  output  8  registered F.
- CO_Q  output  1  registered CN8.
- ZF_Q  output  1  registered zero flag (F == 0).

## Operation
- Let A=DR1, B=DR2, cin = ~Cn.
- Logic mode (M=1), bitwise F for S=0..F:
  - 0–3: ~A, ~(A|B), ~A&B, 8'h00
  - 4–7: ~(A&B), ~B, A^B, A&~B
  - 8–B: ~A|B, ~(A^B), B, A&B
  - C–F: 8'hFF, A|~B, A|B, A
  - CN8 = 0 in logic mode.
- Arithmetic mode (M=0):
  - X = A | (B & {8{S0}}) | (~B & {8{S1}})
  - Y = (A & ~B & {8{S2}}) | (A & B & {8{S3}})
  - {CN8, F} = X + Y + cin, a 9-bit sum. F wraps modulo 256.
- Arithmetic functions with Cn=1:
  - 0–3: A, A|B, A|~B, minus 1 (FF)
  - 4–7: A+(A&~B), (A|B)+(A&~B), A−B−1, (A&~B)−1
  - 8–B: A+(A&B), A+B, (A|~B)+(A&B), (A&B)−1
  - C–F: A+A, (A|B)+A, (A|~B)+A, A−1
  - Cn=0 adds 1 to each. Code 6 with Cn=0 is A−B.
- Bus output:
  - AUJ3 = F when ALU_B=0, all-Z when ALU_B=1.
  - ALU_B does not affect CN8 or the registered outputs.
- Any X/Z on a select input may propagate X to F. No special handling is required.

## Timing
- AUJ3 and CN8 are purely combinational. They are valid within the same delta/propagation time as input changes and need no clock; bus consumers sample them within the same cycle.
- On each rising clk:
  - rst=1: ALU_Q ← 8'h00, CO_Q ← 0, ZF_Q ← 0.
  - rst=0: ALU_Q ← F, CO_Q ← CN8, ZF_Q ← (F == 8'h00).
- Registered outputs show the result one cycle after the operands are applied.
- Reset has no effect on AUJ3/CN8.
- Asserting rst mid-operation clears the registers at that edge only. Capture resumes on the first edge with rst=0.
- The registers capture every cycle. There is no enable and no hold state.

## Test plan
- DR1=8'h65, DR2=8'hA7, M=0, S=9:
  - Cn=1 → AUJ3=8'h0C, CN8=1.
  - Cn=0 → AUJ3=8'h0D.
  - After one clk: ALU_Q=8'h0D, CO_Q=1, ZF_Q=0.
- Same operands, M=0, S=6:
  - Cn=0 → AUJ3=8'hBE (A−B), CN8=0.
  - Cn=1 → AUJ3=8'hBD.
- Same operands, M=1:
  - S=6 → 8'hC2; S=B → 8'h25; S=E → 8'hE7; S=0 → 8'h9A.
  - S=3 → 8'h00, and ZF_Q=1 after the clk.
  - CN8=0 in all cases.
- ALU_B=1 with any function → AUJ3=8'hZZ while ALU_Q still updates on clk. Returning ALU_B to 0 restores the driven value immediately.
- Hold rst=1 across two edges with M=0, S=9, Cn=0 → ALU_Q=00, CO_Q=0, ZF_Q=0, while AUJ3 shows 8'h0D. Deassert rst → next edge loads 8'h0D / CO_Q=1.
- Sweep all 64 combinations of {S, Cn, M} with the fixed operands 8'h65/8'hA7 at 100 ns spacing. Compare AUJ3 against a reference model 1 ns after each change, covering the full function table.
